// File: rtl/proc_control_fsm.sv
// Multi-cycle T0..T3 control unit for the 16-bit simple processor; latches IR, drives datapath enables.
// Optional build macro PROC_CTRL_SHIFT_EN enables sll/srl on opcodes 110/111 (otherwise they are NOPs).
module proc_control_fsm (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        run_i,
    input  logic [15:0] din_i,
    output logic [8:0]  ir_o,
    output logic [7:0]  rin_o,
    output logic [7:0]  rout_o,
    output logic        ain_o,
    output logic        gin_o,
    output logic        gout_o,
    output logic        dinout_o,
    output logic        irin_o,
    output logic [2:0]  aluop_o,
    output logic        done_o
);
    // state | meaning
    // T0    | fetch: IRin = Run, latch DIN[8:0] when Run
    // T1    | mv/mvi complete, or ALU op loads A from Rx
    // T2    | ALU op: Ry on bus, G <= A op bus
    // T3    | ALU op: G written back to Rx
    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;

    logic [1:0] step_q, step_d;
    logic [8:0] ir_q, ir_d;
    logic [2:0] opcode;
    logic [7:0] x_onehot, y_onehot;
    logic       is_alu;
    logic       unused_din;

    assign opcode   = ir_q[8:6];
    assign x_onehot = 8'b1 << ir_q[5:3];
    assign y_onehot = 8'b1 << ir_q[2:0];
    assign unused_din = ^din_i[15:9];

`ifdef PROC_CTRL_SHIFT_EN
    assign is_alu = (opcode != OP_MV) && (opcode != OP_MVI);
`else
    assign is_alu = (opcode >= 3'b010) && (opcode <= 3'b101);
`endif

    always_comb begin
        step_d   = step_q;
        ir_d     = ir_q;
        rin_o    = 8'h00;
        rout_o   = 8'h00;
        ain_o    = 1'b0;
        gin_o    = 1'b0;
        gout_o   = 1'b0;
        dinout_o = 1'b0;
        irin_o   = 1'b0;
        aluop_o  = 3'b000;
        done_o   = 1'b0;
        case (step_q)
            T0: begin
                irin_o = run_i;
                if (run_i) begin
                    ir_d   = din_i[8:0];
                    step_d = T1;
                end
            end
            T1: begin
                if (opcode == OP_MV) begin
                    rout_o = y_onehot;
                    rin_o  = x_onehot;
                    done_o = 1'b1;
                    step_d = T0;
                end else if (opcode == OP_MVI) begin
                    dinout_o = 1'b1;
                    rin_o    = x_onehot;
                    done_o   = 1'b1;
                    step_d   = T0;
                end else if (is_alu) begin
                    rout_o = x_onehot;
                    ain_o  = 1'b1;
                    step_d = T2;
                end else begin
                    // shift opcodes with shifts compiled out retire as a NOP
                    done_o = 1'b1;
                    step_d = T0;
                end
            end
            T2: begin
                rout_o = y_onehot;
                gin_o  = 1'b1;
                case (opcode)
                    3'b010:  aluop_o = 3'b000;
                    3'b011:  aluop_o = 3'b001;
                    3'b100:  aluop_o = 3'b010;
                    3'b101:  aluop_o = 3'b011;
`ifdef PROC_CTRL_SHIFT_EN
                    3'b110:  aluop_o = 3'b100;
                    3'b111:  aluop_o = 3'b101;
`endif
                    default: aluop_o = 3'b000;
                endcase
                step_d = T3;
            end
            default: begin
                gout_o = 1'b1;
                rin_o  = x_onehot;
                done_o = 1'b1;
                step_d = T0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            step_q <= T0;
            ir_q   <= 9'd0;
        end else begin
            step_q <= step_d;
            ir_q   <= ir_d;
        end
    end

    assign ir_o = ir_q;

endmodule

// File: tb/tb_proc_control_fsm.sv
// Scoreboard bench for proc_control_fsm: an instruction-level model expands each fetched
// instruction into its per-step output list; a monitor compares every cycle.
module tb_proc_control_fsm;
    typedef struct packed {
        logic [8:0] ir;
        logic [7:0] rin;
        logic [7:0] rout;
        logic       ain;
        logic       gin;
        logic       gout;
        logic       dinout;
        logic       irin;
        logic [2:0] aluop;
        logic       done;
    } exp_t;

`ifdef PROC_CTRL_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        run_i = 1'b0;
    logic [15:0] din_i = 16'h0000;
    logic [8:0]  ir_o;
    logic [7:0]  rin_o, rout_o;
    logic        ain_o, gin_o, gout_o, dinout_o, irin_o, done_o;
    logic [2:0]  aluop_o;

    int   checks = 0;
    int   errors = 0;
    int   cycle_no = 0;
    exp_t sb_q[$];
    exp_t pending[$];
    logic [8:0] model_ir = 9'd0;

    proc_control_fsm dut (
        .clk_i(clk), .reset_i(reset_i), .run_i(run_i), .din_i(din_i),
        .ir_o(ir_o), .rin_o(rin_o), .rout_o(rout_o), .ain_o(ain_o),
        .gin_o(gin_o), .gout_o(gout_o), .dinout_o(dinout_o), .irin_o(irin_o),
        .aluop_o(aluop_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    exp_t act;
    assign act = '{ir: ir_o, rin: rin_o, rout: rout_o, ain: ain_o, gin: gin_o,
                   gout: gout_o, dinout: dinout_o, irin: irin_o, aluop: aluop_o, done: done_o};

    function automatic logic [2:0] alu_code(input logic [2:0] op);
        case (op)
            3'b010:  return 3'b000;
            3'b011:  return 3'b001;
            3'b100:  return 3'b010;
            3'b101:  return 3'b011;
            3'b110:  return 3'b100;
            default: return 3'b101;
        endcase
    endfunction

    // Instruction semantics: list of (T1.., final) step outputs after the fetch cycle.
    task automatic expand(input logic [8:0] ir);
        exp_t e;
        logic [2:0] op = ir[8:6];
        int x = int'(ir[5:3]);
        int y = int'(ir[2:0]);
        e = '0;
        e.ir = ir;
        if (op == 3'b000) begin
            e.rout = 8'(1 << y); e.rin = 8'(1 << x); e.done = 1'b1;
            pending.push_back(e);
        end else if (op == 3'b001) begin
            e.dinout = 1'b1; e.rin = 8'(1 << x); e.done = 1'b1;
            pending.push_back(e);
        end else if (op >= 3'b110 && !SHIFT_EN) begin
            e.done = 1'b1;
            pending.push_back(e);
        end else begin
            e.rout = 8'(1 << x); e.ain = 1'b1;
            pending.push_back(e);
            e = '0; e.ir = ir;
            e.rout = 8'(1 << y); e.gin = 1'b1; e.aluop = alu_code(op);
            pending.push_back(e);
            e = '0; e.ir = ir;
            e.gout = 1'b1; e.rin = 8'(1 << x); e.done = 1'b1;
            pending.push_back(e);
        end
    endtask

    // Drive one cycle, record what the DUT must show during it, then advance past the edge.
    task automatic cyc(input logic rst, input logic run, input logic [15:0] din);
        exp_t e;
        reset_i = rst;
        run_i   = run;
        din_i   = din;
        if (pending.size() == 0) begin
            e = '0;
            e.ir = model_ir;
            e.irin = run;
            if (!rst && run) begin
                model_ir = din[8:0];
                expand(model_ir);
            end
        end else begin
            e = pending.pop_front();
        end
        if (rst) begin
            pending.delete();
            model_ir = 9'd0;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL cycle%0d outputs: got ir=%h rin=%h rout=%h ain=%b gin=%b gout=%b dinout=%b irin=%b aluop=%b done=%b, want ir=%h rin=%h rout=%h ain=%b gin=%b gout=%b dinout=%b irin=%b aluop=%b done=%b",
                             cycle_no, act.ir, act.rin, act.rout, act.ain, act.gin, act.gout, act.dinout,
                             act.irin, act.aluop, act.done, e.ir, e.rin, e.rout, e.ain, e.gin, e.gout,
                             e.dinout, e.irin, e.aluop, e.done);
                end
                cycle_no++;
            end
        end
    end

    initial begin : stimulus
        repeat (2) @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, 16'h0000);
        repeat (5) cyc(1'b0, 1'b0, 16'(($urandom) & 16'hFFFF));
        // mvi R2, #A5
        cyc(1'b0, 1'b1, 16'h0050);
        cyc(1'b0, 1'b0, 16'h00A5);
        cyc(1'b0, 1'b0, 16'h0000);
        // add R1,R5
        cyc(1'b0, 1'b1, 16'h008D);
        repeat (3) cyc(1'b0, 1'b0, 16'h0000);
        // slt R0,R7 then sub R7,R0 with Run held high
        cyc(1'b0, 1'b1, 16'h0147);
        repeat (3) cyc(1'b0, 1'b1, 16'h01FF);
        cyc(1'b0, 1'b1, 16'h00F8);
        repeat (3) cyc(1'b0, 1'b1, 16'h0000);
        cyc(1'b0, 1'b0, 16'h0000);
        // or R2,R6 with reset during T2
        cyc(1'b0, 1'b1, 16'h0116);
        cyc(1'b0, 1'b0, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 16'h0000);
        // srl R4,R1
        cyc(1'b0, 1'b1, 16'h01E1);
        repeat (3) cyc(1'b0, 1'b0, 16'h0000);
        // mv R3,R3
        cyc(1'b0, 1'b1, 16'h001B);
        cyc(1'b0, 1'b0, 16'h0000);
        // randomized instruction stream, including occasional resets
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                16'($urandom & 16'hFFFF));
        end
        repeat (2) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/proc_control_fsm.md
# proc_control_fsm

Multi-cycle control unit for the 16-bit simple processor. It latches a 9-bit instruction from `DIN` and walks a T0–T3 step sequence. In each step it drives the one-hot register enables, the bus-source selects and the 3-bit ALU operation code that sequence the register file, the A/G registers and the ALU. It sits between the instruction source (`DIN`/`Run`) and the datapath; it contains no data registers other than IR.

## Interface
- No parameters; widths fixed (16-bit data, 8 registers, 9-bit instruction).
- `Clock` in 1: single system clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `Run` in 1: start request, sampled only in T0.
- `DIN` in 16: instruction in T0; immediate operand in T1 of `mvi`. IR = `DIN[8:0]` = III XXX YYY.
- `IR` out 9: latched instruction (debug/observability).
- `Rin` out 8: one-hot write enable for R0..R7.
- `Rout` out 8: one-hot bus-drive select for R0..R7.
- `Ain` out 1: load A register from bus.
- `Gin` out 1: load G register from ALU result.
- `Gout` out 1: G drives bus.
- `DINout` out 1: DIN drives bus.
- `IRin` out 1: IR load strobe (internal IR loads on the same edge).
- `ALUop` out 3: ALU control (000 add, 001 sub, 010 or, 011 slt, 100 sll, 101 srl).
- `Done` out 1: one-cycle pulse in the final step of each instruction.

## Operation
- Opcodes (`IR[8:6]`):
  - 000 mv
  - 001 mvi
  - 010 add
  - 011 sub
  - 100 or
  - 101 slt
  - 110 sll
  - 111 srl
- X = `IR[5:3]`, Y = `IR[2:0]`.
- States: T0, T1, T2, T3, encoded in a 2-bit step register.
- T0: `IRin` = `Run`. If `Run`=1, IR <= `DIN[8:0]` and go to T1; else stay in T0.
- `mv`: T1 → `Rout[Y]`, `Rin[X]`, `Done`; next T0.
- `mvi`: T1 → `DINout`, `Rin[X]`, `Done`; next T0.
- ALU ops:
  - T1: `Rout[X]`, `Ain`.
  - T2: `Rout[Y]`, `Gin`, `ALUop` per mapping (add→000, sub→001, or→010, slt→011, sll→100, srl→101).
  - T3: `Gout`, `Rin[X]`, `Done`; next T0.
- Control outputs are combinational from (step, IR). All other outputs are 0 in each step.
- `ALUop` = 000 whenever `Gin`=0.
- At most one of `Rout`/`Gout`/`DINout` is active in any cycle. With none active, the bus source is "none".
- `Run` is ignored in T1–T3; it cannot abort or restart an instruction.
- X = Y is legal; `mv R3,R3` asserts `Rout[3]` and `Rin[3]` together.

## Timing
- Reset state: step = T0, IR = 0. The next cycle shows all outputs 0 except `IRin` = `Run`.
- Reset mid-instruction: return to T0 on that edge. No `Done`, no `Rin` in the following cycle, IR cleared.
- Latency (Run sampled → `Done` cycle):
  - `mv`/`mvi`: `Done` in the cycle after the T0 edge (2 cycles total incl. T0).
  - ALU ops: `Done` in the third cycle after T0 (4 cycles total).
- Back-to-back: with `Run` held high, the cycle after `Done` is T0 and loads the next instruction. No bubble beyond T0.
- `DIN` must hold the immediate during the `mvi` T1 cycle.

## Configuration
- Macro: `PROC_CTRL_SHIFT_EN`.
- Defined: opcodes 110/111 execute `sll`/`srl` via `ALUop` 100/101 as above.
- Undefined: opcodes 110/111 are NOPs.
  - T1 asserts `Done` only.
  - No `Rin`, `Ain` or `Gin` is asserted.
  - Next state is T0.
  - `ALUop` values 100/101 are never produced.

## Test plan
- Reset, then hold `Run`=0 for 5 cycles → step stays T0, `Rin`=0, `Rout`=0, `Done`=0 every cycle, IR=0.
- `Run`=1, `DIN`=9'b001_010_000 (mvi R2), then `DIN`=16'h00A5 in T1 → T1 shows `DINout`=1, `Rin`=8'b0000_0100, `Done`=1; next cycle T0.
- `add R1,R5` (010_001_101) → T1 `Rout`=8'h02 `Ain`=1; T2 `Rout`=8'h20 `Gin`=1 `ALUop`=000; T3 `Gout`=1 `Rin`=8'h02 `Done`=1.
- `slt R0,R7` followed immediately by `sub R7,R0` with `Run` held high → `ALUop` 011, then 001. The second IR loads in the cycle after the first `Done`, with no idle cycle.
- Assert `Reset` during T2 of an `or` → next cycle step=T0, IR=0, `Gin`=0, no `Done`/`Rin` issued for that instruction.
- `srl R4,R1` (111_100_001) → with `PROC_CTRL_SHIFT_EN`: T2 `ALUop`=101, T3 `Rin`=8'h10. Without it: T1 `Done`=1, all enables 0, back to T0.
